// File: rtl/invaders_mem_pkg.sv
// Shared types and helpers for the Invaders memory controller.
//   mode_t   : game variant selected by the framework (plain/vortex/attackforce/cosmo)
//   state_t  : controller phase (work-RAM clear, normal run, download)
//   region_t : CPU read region, registered alongside the read address
//   scramble : per-variant program ROM address permutation
package invaders_mem_pkg;

   typedef enum logic [1:0] {
      MODE_PLAIN  = 2'd0,
      MODE_VORTEX = 2'd1,
      MODE_ATTACK = 2'd2,
      MODE_COSMO  = 2'd3
   } mode_t;

   typedef logic [1:0] state_t;
   localparam state_t ST_CLEAR = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_LOAD  = 2'd2;

   typedef enum logic [1:0] {
      RG_NONE = 2'd0,
      RG_ROM  = 2'd1,
      RG_CRAM = 2'd2
   } region_t;

   // Download address bits [15:13] select the target: bank index, or colour PROM
   // when equal to the bank count.
   localparam int DL_SEL_LSB = 13;

   function automatic logic [15:0] scramble(input logic [15:0] a, input mode_t m);
      logic [15:0] s;
      s = a;
      case (m)
         MODE_VORTEX: s = a ^ 16'h0209;
         MODE_ATTACK: begin
            s[9] = a[8];
            s[8] = a[9];
         end
         default: s = a;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/invaders_dl_tracker.sv
// Download sequencing and work-RAM clear control.
//   Clock, Reset_n        : clock, asynchronous active-low reset
//   dn_download, dn_addr, dn_wr : framework download bus (only what the tracker needs)
//   state                 : current phase (CLEAR/RUN/LOAD)
//   clear_addr            : work-RAM address being zeroed while in CLEAR
//   Bank_loaded           : per-bank flag, set when the last byte of a bank is written
//   Load_done             : set when the clear following a download completes
//   Clear_busy            : high for the whole CLEAR phase
module invaders_dl_tracker
   import invaders_mem_pkg::*;
#(
   parameter int ROM_BANKS = 2,
   parameter int ROM_AW    = 13,
   parameter int RAM_AW    = 13
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic                 dn_download,
   input  logic [15:0]          dn_addr,
   input  logic                 dn_wr,
   output state_t               state,
   output logic [RAM_AW-1:0]    clear_addr,
   output logic [ROM_BANKS-1:0] Bank_loaded,
   output logic                 Load_done,
   output logic                 Clear_busy
);

   localparam logic [RAM_AW-1:0] CLEAR_LAST = '1;
   localparam logic [ROM_AW-1:0] BANK_LAST  = '1;

   logic dl_p1;
   logic load_seen;
   logic rise;
   logic fall;

   assign rise       = dn_download & ~dl_p1;
   assign fall       = ~dn_download & dl_p1;
   assign Clear_busy = (state == ST_CLEAR);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= ST_CLEAR;
         clear_addr  <= '0;
         dl_p1       <= 1'b0;
         load_seen   <= 1'b0;
         Bank_loaded <= '0;
         Load_done   <= 1'b0;
      end else begin
         dl_p1 <= dn_download;
         case (state)
            ST_CLEAR: begin
               if (rise) begin
                  // a new session pre-empts the clear; it restarts from 0 afterwards
                  state       <= ST_LOAD;
                  Bank_loaded <= '0;
                  Load_done   <= 1'b0;
               end else if (clear_addr == CLEAR_LAST) begin
                  state      <= ST_RUN;
                  clear_addr <= '0;
                  load_seen  <= 1'b0;
                  if (load_seen) Load_done <= 1'b1;
               end else begin
                  clear_addr <= clear_addr + 1'b1;
               end
            end
            ST_RUN: begin
               if (rise) begin
                  state       <= ST_LOAD;
                  Bank_loaded <= '0;
                  Load_done   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (dn_wr && dn_addr[ROM_AW-1:0] == BANK_LAST) begin
                  for (int i = 0; i < ROM_BANKS; i++) begin
                     if (dn_addr[15:DL_SEL_LSB] == 3'(i)) Bank_loaded[i] <= 1'b1;
                  end
               end
               if (fall) begin
                  state      <= ST_CLEAR;
                  clear_addr <= '0;
                  load_seen  <= 1'b1;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: rtl/invaders_memory_ctrl.sv
// Invaders memory map: ROM banks, colour PROM/RAM and work RAM, all loadable
// over the download bus, with registered read muxing (1-clock latency).
//   Addr/CPU_RW_n/Cpu_in/Rom_out     : CPU ROM and colour-RAM space
//   Ram_Addr/RW_n/Ram_in/Ram_out     : work RAM (CPU or video)
//   color_prom_addr/color_prom_out   : video colour lookup
//   dn_download/dn_addr/dn_data/dn_wr: framework download port
//   mode                             : game variant
//   Bank_loaded/Load_done/Clear_busy/Cram_collision : status
module invaders_memory_ctrl
   import invaders_mem_pkg::*;
#(
   parameter int          ROM_BANKS = 2,
   parameter int          ROM_AW    = 13,
   parameter int          RAM_AW    = 13,
   parameter int          CRAM_AW   = 11,
   parameter logic [15:0] CRAM_BASE = 16'h5C00
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic [15:0]          Addr,
   input  logic                 CPU_RW_n,
   input  logic [7:0]           Cpu_in,
   output logic [7:0]           Rom_out,
   input  logic [15:0]          Ram_Addr,
   input  logic                 RW_n,
   input  logic [7:0]           Ram_in,
   output logic [7:0]           Ram_out,
   input  logic [CRAM_AW-1:0]   color_prom_addr,
   output logic [7:0]           color_prom_out,
   input  logic                 dn_download,
   input  logic [15:0]          dn_addr,
   input  logic [7:0]           dn_data,
   input  logic                 dn_wr,
   input  logic [1:0]           mode,
   output logic [ROM_BANKS-1:0] Bank_loaded,
   output logic                 Load_done,
   output logic                 Clear_busy,
   output logic                 Cram_collision
);

   state_t            state;
   logic [RAM_AW-1:0] clear_addr;

   invaders_dl_tracker #(
      .ROM_BANKS(ROM_BANKS),
      .ROM_AW   (ROM_AW),
      .RAM_AW   (RAM_AW)
   ) u_tracker (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .dn_download(dn_download),
      .dn_addr    (dn_addr),
      .dn_wr      (dn_wr),
      .state      (state),
      .clear_addr (clear_addr),
      .Bank_loaded(Bank_loaded),
      .Load_done  (Load_done),
      .Clear_busy (Clear_busy)
   );

   mode_t       mode_e;
   logic [15:0] rom_addr;
   logic        cpu_cwin;
   logic        cpu_wreq;
   logic        dl_cwr;
   logic        cpu_cwr;
   logic        dl_active;
   logic        unused_bits;

   assign mode_e    = mode_t'(mode);
   assign rom_addr  = scramble(Addr, mode_e);
   assign dl_active = (state == ST_LOAD) && dn_wr;
   assign cpu_cwin  = (mode_e == MODE_COSMO) &&
                      (Addr[15:CRAM_AW-1] == CRAM_BASE[15:CRAM_AW-1]);
   assign cpu_wreq  = cpu_cwin && !CPU_RW_n;
   assign dl_cwr    = dl_active && (dn_addr[15:DL_SEL_LSB] == 3'(ROM_BANKS));
   // download owns the colour write port whenever it writes
   assign cpu_cwr   = cpu_wreq && (state == ST_RUN) && !dl_cwr;
   assign unused_bits = ^{Ram_Addr[15:RAM_AW], rom_addr[15:ROM_AW]};

   region_t    region;
   logic [1:0] bank;

   always_comb begin
      region = RG_NONE;
      bank   = 2'd0;
      if (cpu_cwin) begin
         region = RG_CRAM;
      end else if (!Addr[13] && ({1'b0, Addr[15:14]} < 3'(ROM_BANKS))) begin
         region = RG_ROM;
         bank   = Addr[15:14];
      end
   end

   // ---- stage p1: memory reads (no reset on data) ----
   logic [7:0] rom_q_p1 [ROM_BANKS];

   for (genvar i = 0; i < ROM_BANKS; i++) begin : g_rom
      logic [7:0] mem [2**ROM_AW];
      always_ff @(posedge Clock) begin
         if (dl_active && dn_addr[15:DL_SEL_LSB] == 3'(i)) mem[dn_addr[ROM_AW-1:0]] <= dn_data;
         rom_q_p1[i] <= mem[rom_addr[ROM_AW-1:0]];
      end
   end

   logic [7:0]         cram [2**CRAM_AW];
   logic [7:0]         cram_a_p1;
   logic [7:0]         cram_b_p1;
   logic [CRAM_AW-1:0] cram_wa;
   logic [7:0]         cram_wd;

   assign cram_wa = dl_cwr ? dn_addr[CRAM_AW-1:0] : Addr[CRAM_AW-1:0];
   assign cram_wd = dl_cwr ? dn_data : Cpu_in;

   always_ff @(posedge Clock) begin
      if (dl_cwr || cpu_cwr) cram[cram_wa] <= cram_wd;
      cram_a_p1 <= cram[Addr[CRAM_AW-1:0]];
      cram_b_p1 <= cram[color_prom_addr];
   end

   logic [7:0]        ram [2**RAM_AW];
   logic [7:0]        ram_q_p1;
   logic              clearing;
   logic [RAM_AW-1:0] ram_wa;

   assign clearing = (state == ST_CLEAR);
   assign ram_wa   = clearing ? clear_addr : Ram_Addr[RAM_AW-1:0];

   always_ff @(posedge Clock) begin
      if (clearing || !RW_n) ram[ram_wa] <= clearing ? 8'h00 : Ram_in;
      ram_q_p1 <= ram[Ram_Addr[RAM_AW-1:0]];
   end

   // ---- stage p1: control registered with the read address ----
   region_t    region_p1;
   logic [1:0] bank_p1;
   logic       ram_vld_p1;
   logic       vld_p1;
   logic       vortex_p1;
   logic [2:0] gen_p1;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         region_p1      <= RG_NONE;
         bank_p1        <= 2'd0;
         ram_vld_p1     <= 1'b0;
         vld_p1         <= 1'b0;
         vortex_p1      <= 1'b0;
         gen_p1         <= 3'd0;
         Cram_collision <= 1'b0;
      end else begin
         region_p1  <= region;
         bank_p1    <= bank;
         ram_vld_p1 <= !clearing;
         vld_p1     <= 1'b1;
         vortex_p1  <= (mode_e == MODE_VORTEX);
         gen_p1     <= {Addr[12], ~color_prom_addr[1], ~Addr[12]};
         if (cpu_wreq && dl_cwr) Cram_collision <= 1'b1;
      end
   end

   always_comb begin
      Rom_out = 8'h00;
      case (region_p1)
         RG_ROM: begin
            for (int i = 0; i < ROM_BANKS; i++) begin
               if (bank_p1 == 2'(i)) Rom_out = rom_q_p1[i];
            end
         end
         RG_CRAM: Rom_out = cram_a_p1;
         default: Rom_out = 8'h00;
      endcase
   end

   assign Ram_out        = (ram_vld_p1 && !clearing) ? ram_q_p1 : 8'h00;
   assign color_prom_out = !vld_p1   ? 8'h00 :
                           vortex_p1 ? {5'b0, gen_p1} : cram_b_p1;

endmodule

// File: tb/tb_invaders_memory_ctrl.sv
// Directed bench for invaders_memory_ctrl (default parameters, 2 ROM banks).
module tb_invaders_memory_ctrl;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [15:0] Addr;
   logic        CPU_RW_n;
   logic [7:0]  Cpu_in;
   logic [7:0]  Rom_out;
   logic [15:0] Ram_Addr;
   logic        RW_n;
   logic [7:0]  Ram_in;
   logic [7:0]  Ram_out;
   logic [10:0] color_prom_addr;
   logic [7:0]  color_prom_out;
   logic        dn_download;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic [1:0]  mode;
   logic [1:0]  Bank_loaded;
   logic        Load_done;
   logic        Clear_busy;
   logic        Cram_collision;

   int total = 0;
   int bad   = 0;

   always #5 Clock = ~Clock;

   invaders_memory_ctrl dut (
      .Clock(Clock), .Reset_n(Reset_n), .Addr(Addr), .CPU_RW_n(CPU_RW_n), .Cpu_in(Cpu_in),
      .Rom_out(Rom_out), .Ram_Addr(Ram_Addr), .RW_n(RW_n), .Ram_in(Ram_in), .Ram_out(Ram_out),
      .color_prom_addr(color_prom_addr), .color_prom_out(color_prom_out),
      .dn_download(dn_download), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
      .mode(mode), .Bank_loaded(Bank_loaded), .Load_done(Load_done),
      .Clear_busy(Clear_busy), .Cram_collision(Cram_collision)
   );

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      while (Clear_busy === 1'b1 && n < 10000) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset;
      int n;
      Reset_n = 1'b0;
      tick(); tick();
      total++; if (Rom_out !== 8'h00) begin bad++; $display("FAIL rst_rom got=%h exp=00", Rom_out); end
      total++; if (Ram_out !== 8'h00) begin bad++; $display("FAIL rst_ram got=%h exp=00", Ram_out); end
      total++; if (color_prom_out !== 8'h00) begin bad++; $display("FAIL rst_cprom got=%h exp=00", color_prom_out); end
      total++; if ({Bank_loaded, Load_done, Cram_collision, Clear_busy} !== 5'b00001) begin
         bad++; $display("FAIL rst_flags got=%b exp=00001", {Bank_loaded, Load_done, Cram_collision, Clear_busy});
      end
      Reset_n = 1'b1;
      wait_clear(n);
      total++; if (n != 8192) begin bad++; $display("FAIL rst_clear_len got=%0d exp=8192", n); end
      total++; if (Load_done !== 1'b0) begin bad++; $display("FAIL rst_load_done got=%b exp=0", Load_done); end
   endtask

   task automatic test_ram_rw;
      Ram_Addr = 16'h0000; Ram_in = 8'h11; RW_n = 1'b0; tick();
      Ram_Addr = 16'h1FFF; Ram_in = 8'h22; tick();
      RW_n = 1'b1; Ram_Addr = 16'h0000; tick();
      total++; if (Ram_out !== 8'h11) begin bad++; $display("FAIL ram_rd0 got=%h exp=11", Ram_out); end
      Ram_Addr = 16'h1FFF; tick();
      total++; if (Ram_out !== 8'h22) begin bad++; $display("FAIL ram_rd1fff got=%h exp=22", Ram_out); end
   endtask

   task automatic test_download;
      int n;
      dn_download = 1'b1; tick();
      for (int a = 0; a < 16384; a++) begin
         dn_addr = 16'(a);
         dn_data = (a == 16'h0209) ? 8'hAB : (8'(a) ^ 8'(a >> 8) ^ 8'h5A);
         dn_wr   = 1'b1;
         tick();
         if (a == 16'h1FFE) begin
            total++; if (Bank_loaded !== 2'b00) begin bad++; $display("FAIL bank_1ffe got=%b exp=00", Bank_loaded); end
         end
         if (a == 16'h1FFF) begin
            total++; if (Bank_loaded !== 2'b01) begin bad++; $display("FAIL bank_1fff got=%b exp=01", Bank_loaded); end
         end
      end
      dn_wr = 1'b0;
      total++; if (Bank_loaded !== 2'b11) begin bad++; $display("FAIL bank_3fff got=%b exp=11", Bank_loaded); end
      dn_download = 1'b0; tick();
      total++; if ({Clear_busy, Load_done} !== 2'b10) begin
         bad++; $display("FAIL dl_clear_start got=%b exp=10", {Clear_busy, Load_done});
      end
      wait_clear(n);
      total++; if (n != 8192) begin bad++; $display("FAIL dl_clear_len got=%0d exp=8192", n); end
      total++; if (Load_done !== 1'b1) begin bad++; $display("FAIL dl_load_done got=%b exp=1", Load_done); end
      Ram_Addr = 16'h0000; tick();
      total++; if (Ram_out !== 8'h00) begin bad++; $display("FAIL dl_ram0 got=%h exp=00", Ram_out); end
      Ram_Addr = 16'h1FFF; tick();
      total++; if (Ram_out !== 8'h00) begin bad++; $display("FAIL dl_ram1fff got=%h exp=00", Ram_out); end
   endtask

   task automatic test_back_to_back;
      mode = 2'd0;
      Addr = 16'h0000; tick();
      total++; if (Rom_out !== 8'h5A) begin bad++; $display("FAIL b2b_bank0 got=%h exp=5a", Rom_out); end
      Addr = 16'h4000; tick();
      total++; if (Rom_out !== 8'h7A) begin bad++; $display("FAIL b2b_bank1 got=%h exp=7a", Rom_out); end
      Addr = 16'h8000; tick();
      total++; if (Rom_out !== 8'h00) begin bad++; $display("FAIL b2b_unmapped got=%h exp=00", Rom_out); end
      Addr = 16'h1234; tick();
      total++; if (Rom_out !== 8'h7C) begin bad++; $display("FAIL rd_1234 got=%h exp=7c", Rom_out); end
      Addr = 16'h2000; tick();
      total++; if (Rom_out !== 8'h00) begin bad++; $display("FAIL rd_2000 got=%h exp=00", Rom_out); end
      Addr = 16'h5C10; tick();
      total++; if (Rom_out !== 8'h76) begin bad++; $display("FAIL rd_5c10_plain got=%h exp=76", Rom_out); end
      Addr = 16'h6000; tick();
      total++; if (Rom_out !== 8'h00) begin bad++; $display("FAIL rd_6000 got=%h exp=00", Rom_out); end
   endtask

   task automatic test_scramble;
      mode = 2'd1; Addr = 16'h0000; tick();
      total++; if (Rom_out !== 8'hAB) begin bad++; $display("FAIL vortex_0000 got=%h exp=ab", Rom_out); end
      Addr = 16'h0209; tick();
      total++; if (Rom_out !== 8'h5A) begin bad++; $display("FAIL vortex_0209 got=%h exp=5a", Rom_out); end
      mode = 2'd2; Addr = 16'h0100; tick();
      total++; if (Rom_out !== 8'h58) begin bad++; $display("FAIL attack_0100 got=%h exp=58", Rom_out); end
      Addr = 16'h0200; tick();
      total++; if (Rom_out !== 8'h5B) begin bad++; $display("FAIL attack_0200 got=%h exp=5b", Rom_out); end
      mode = 2'd3; Addr = 16'h0000; tick();
      total++; if (Rom_out !== 8'h5A) begin bad++; $display("FAIL cosmo_0000 got=%h exp=5a", Rom_out); end
      mode = 2'd1; Addr = 16'h1000; color_prom_addr = 11'h000; tick();
      total++; if (color_prom_out !== 8'h06) begin bad++; $display("FAIL vgen_a1_c0 got=%h exp=06", color_prom_out); end
      color_prom_addr = 11'h002; tick();
      total++; if (color_prom_out !== 8'h04) begin bad++; $display("FAIL vgen_a1_c2 got=%h exp=04", color_prom_out); end
      Addr = 16'h0000; tick();
      total++; if (color_prom_out !== 8'h01) begin bad++; $display("FAIL vgen_a0_c2 got=%h exp=01", color_prom_out); end
   endtask

   task automatic test_cram;
      mode = 2'd3; Addr = 16'h5C10; Cpu_in = 8'h3C; CPU_RW_n = 1'b0; tick();
      CPU_RW_n = 1'b1; tick();
      total++; if (Rom_out !== 8'h3C) begin bad++; $display("FAIL cram_rd got=%h exp=3c", Rom_out); end
      color_prom_addr = 11'h410; tick();
      total++; if (color_prom_out !== 8'h3C) begin bad++; $display("FAIL cram_video got=%h exp=3c", color_prom_out); end
      mode = 2'd0; Cpu_in = 8'h99; CPU_RW_n = 1'b0; tick();
      CPU_RW_n = 1'b1; mode = 2'd3; tick();
      total++; if (Rom_out !== 8'h3C) begin bad++; $display("FAIL cram_plain_wr got=%h exp=3c", Rom_out); end
      mode = 2'd0; dn_addr = 16'h0000; dn_data = 8'hEE; dn_wr = 1'b1; tick();
      dn_wr = 1'b0; Addr = 16'h0000; tick();
      total++; if (Rom_out !== 8'h5A) begin bad++; $display("FAIL dnwr_run got=%h exp=5a", Rom_out); end
      total++; if (Cram_collision !== 1'b0) begin bad++; $display("FAIL coll_idle got=%b exp=0", Cram_collision); end
   endtask

   task automatic test_collision;
      int n;
      mode = 2'd3; dn_download = 1'b1; tick();
      dn_addr = 16'h4410; dn_data = 8'hC5; dn_wr = 1'b1;
      Addr = 16'h5C10; Cpu_in = 8'h11; CPU_RW_n = 1'b0; tick();
      dn_wr = 1'b0; CPU_RW_n = 1'b1;
      total++; if (Cram_collision !== 1'b1) begin bad++; $display("FAIL coll_set got=%b exp=1", Cram_collision); end
      total++; if (Bank_loaded !== 2'b00) begin bad++; $display("FAIL coll_bank got=%b exp=00", Bank_loaded); end
      dn_download = 1'b0; tick();
      wait_clear(n);
      total++; if (n != 8192) begin bad++; $display("FAIL coll_clear_len got=%0d exp=8192", n); end
      color_prom_addr = 11'h410; tick();
      total++; if (Rom_out !== 8'hC5) begin bad++; $display("FAIL coll_cpu_rd got=%h exp=c5", Rom_out); end
      total++; if (color_prom_out !== 8'hC5) begin bad++; $display("FAIL coll_video got=%h exp=c5", color_prom_out); end
   endtask

   task automatic test_abort;
      int n;
      Ram_Addr = 16'h1FFF; Ram_in = 8'h22; RW_n = 1'b0; tick();
      RW_n = 1'b1;
      dn_download = 1'b1; tick();
      dn_download = 1'b0; tick();
      for (int i = 0; i < 256; i++) tick();
      total++; if (Ram_out !== 8'h00) begin bad++; $display("FAIL clr_ram_forced got=%h exp=00", Ram_out); end
      total++; if (Clear_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_mid got=%b exp=1", Clear_busy); end
      dn_download = 1'b1; tick();
      total++; if (Clear_busy !== 1'b0) begin bad++; $display("FAIL abort_load got=%b exp=0", Clear_busy); end
      dn_download = 1'b0; tick();
      Ram_Addr = 16'h0005; Ram_in = 8'h55; RW_n = 1'b0;
      wait_clear(n);
      RW_n = 1'b1;
      total++; if (n != 8192) begin bad++; $display("FAIL abort_clear_len got=%0d exp=8192", n); end
      total++; if (Load_done !== 1'b1) begin bad++; $display("FAIL abort_load_done got=%b exp=1", Load_done); end
      tick();
      total++; if (Ram_out !== 8'h00) begin bad++; $display("FAIL clr_rwn_ignored got=%h exp=00", Ram_out); end
      Ram_Addr = 16'h1FFF; tick();
      total++; if (Ram_out !== 8'h00) begin bad++; $display("FAIL abort_ram1fff got=%h exp=00", Ram_out); end
   endtask

   initial begin
      Reset_n = 1'b0; Addr = 16'h0000; CPU_RW_n = 1'b1; Cpu_in = 8'h00;
      Ram_Addr = 16'h0000; RW_n = 1'b1; Ram_in = 8'h00; color_prom_addr = '0;
      dn_download = 1'b0; dn_addr = 16'h0000; dn_data = 8'h00; dn_wr = 1'b0; mode = 2'd0;
      test_reset();
      test_ram_rw();
      test_download();
      test_back_to_back();
      test_scramble();
      test_cram();
      test_collision();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
